// File: rtl/fsm_out_pkg.sv
// Shared encodings and defaults for the serial-output framer.
// Holds the hunt/collect state type, drop counter width and default sync word.
package fsm_out_pkg;

  localparam logic       ST_HUNT      = 1'b0;
  localparam logic       ST_COLLECT   = 1'b1;
  localparam int         DROP_W       = 8;
  localparam logic [7:0] SYNC_PAT_DEF = 8'hB1;

  typedef enum logic {
    S_HUNT    = ST_HUNT,
    S_COLLECT = ST_COLLECT
  } state_t;

endpackage

// File: rtl/fsm_out_fifo.sv
// Word FIFO, wrap-bit pointers; a push is visible on o_dout the cycle after it is written.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module fsm_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = w_empty;
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/fsm_out_framer.sv
// Hunts a sync word in a serial stream, then deserialises FRAME_WORDS words MSB first into a FIFO.
// Words appear one edge after their last bit; a word meeting a full FIFO with no pop is dropped and counted.
module fsm_out_framer
  import fsm_out_pkg::*;
#(
  parameter int                WORD_W      = 8,
  parameter int                SYNC_W      = 8,
  parameter logic [SYNC_W-1:0] SYNC_PAT    = SYNC_W'(SYNC_PAT_DEF),
  parameter int                FRAME_WORDS = 2,
  parameter int                FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_in,
  input  logic              bit_vld,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              locked,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int BC_W  = $clog2(WORD_W);
  localparam int WC_W  = $clog2(FRAME_WORDS + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t            r_state;
  logic [SYNC_W-1:0] r_hist;
  logic [WORD_W-1:0] r_word;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [WC_W-1:0]   r_word_cnt;
  logic [DROP_W-1:0] r_drop_cnt;

  logic [SYNC_W-1:0] w_hist_next;
  logic [WORD_W-1:0] w_word_next;
  logic              w_word_done;
  logic              w_frame_done;
  logic              w_pop;
  logic              w_drop;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;

  assign w_hist_next  = {r_hist[SYNC_W-2:0], bit_in};
  assign w_word_next  = {r_word[WORD_W-2:0], bit_in};
  assign w_word_done  = bit_vld && (r_state == S_COLLECT) && (r_bit_cnt == BC_W'(WORD_W - 1));
  assign w_frame_done = w_word_done && (r_word_cnt == WC_W'(FRAME_WORDS - 1));
  assign w_pop        = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so only a full FIFO without a pop loses the word.
  assign w_drop       = w_word_done && !w_pop && (w_count == CNT_W'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_HUNT;
      r_hist     <= '0;
      r_word     <= '0;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
      if (bit_vld) begin
        case (r_state)
          S_HUNT: begin
            r_hist <= w_hist_next;
            if (w_hist_next == SYNC_PAT) begin
              r_state    <= S_COLLECT;
              r_bit_cnt  <= '0;
              r_word_cnt <= '0;
            end
          end
          S_COLLECT: begin
            r_word <= w_word_next;
            if (w_word_done) begin
              r_bit_cnt <= '0;
              if (w_frame_done) begin
                r_state    <= S_HUNT;
                r_hist     <= '0;
                r_word_cnt <= '0;
              end else begin
                r_word_cnt <= r_word_cnt + 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

  fsm_out_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_word_done),
    .i_din   (w_word_next),
    .i_pop   (out_ready),
    .o_dout  (out_data),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign out_valid = !w_empty;
  assign locked    = (r_state == S_COLLECT);
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_fsm_out_framer.sv
// Scoreboard bench for fsm_out_framer: expected words are queued as their last bit is driven
// and compared when the DUT hands them out; drops are modelled against a 4-entry occupancy.
module tb_fsm_out_framer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_vld = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       locked;
  logic [7:0] drop_cnt;

  int         n_total = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  int         drop_exp = 0;
  logic       rdy_base = 1'b0;

  always #5 clk = ~clk;

  fsm_out_framer dut (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (bit_in),
    .bit_vld   (bit_vld),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .locked    (locked),
    .drop_cnt  (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, settle on the falling edge, score any handshake, then cross the rising edge.
  task automatic step(input logic b, input logic v, input logic r, input logic last, input logic [7:0] w);
    logic        hs;
    logic [31:0] e;
    bit_in    = b;
    bit_vld   = v;
    out_ready = r;
    @(negedge clk);
    hs = out_valid && out_ready;
    if (hs) begin
      e = (exp_q.size() > 0) ? {24'h0, exp_q[0]} : 32'hDEAD;
      chk("word", {24'h0, out_data}, e);
    end
    if (last) begin
      if (exp_q.size() < 4 || hs) begin
        if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
        exp_q.push_back(w);
        hs = 1'b0;
      end else if (drop_exp < 255) begin
        drop_exp++;
      end
    end
    if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'($urandom_range(0, 1)), 1'b0, rdy_base, 1'b0, 8'h00);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic is_data, input logic toggle, input logic rdy_last);
    for (int i = 7; i >= 0; i--) begin
      step(b[i], 1'b1, (i == 0 && rdy_last) ? 1'b1 : rdy_base, is_data && (i == 0), b);
      if (toggle) step(1'($urandom_range(0, 1)), 1'b0, rdy_base, 1'b0, 8'h00);
    end
  endtask

  task automatic do_reset();
    bit_vld = 1'b0;
    reset   = 1'b0;
    exp_q.delete();
    drop_exp = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    logic [7:0] sync;
    sync = 8'hB1;

    // reset state
    do_reset();
    idle(2);
    chk("rst_valid", {31'h0, out_valid}, 0);
    chk("rst_locked", {31'h0, locked}, 0);
    chk("rst_drop", {24'h0, drop_cnt}, 0);
    chk("rst_data", {24'h0, out_data}, 0);

    // continuous stream, consumer always ready
    rdy_base = 1'b1;
    for (int i = 7; i >= 1; i--) step(sync[i], 1'b1, rdy_base, 1'b0, 8'h00);
    chk("t2_unlocked_7", {31'h0, locked}, 0);
    step(sync[0], 1'b1, rdy_base, 1'b0, 8'h00);
    chk("t2_locked", {31'h0, locked}, 1);
    send_byte(8'h3C, 1'b1, 1'b0, 1'b0);
    chk("t2_locked_mid", {31'h0, locked}, 1);
    send_byte(8'h5A, 1'b1, 1'b0, 1'b0);
    chk("t2_unlocked_end", {31'h0, locked}, 0);
    idle(4);
    chk("t2_sb_left", exp_q.size(), 0);
    chk("t2_valid", {31'h0, out_valid}, 0);
    chk("t2_drop", {24'h0, drop_cnt}, 0);

    // bit_vld toggling every cycle
    send_byte(sync, 1'b0, 1'b1, 1'b0);
    chk("t3_locked", {31'h0, locked}, 1);
    send_byte(8'h3C, 1'b1, 1'b1, 1'b0);
    send_byte(8'h5A, 1'b1, 1'b1, 1'b0);
    chk("t3_unlocked", {31'h0, locked}, 0);
    idle(4);
    chk("t3_sb_left", exp_q.size(), 0);
    chk("t3_valid", {31'h0, out_valid}, 0);

    // overflow with consumer stalled
    rdy_base = 1'b0;
    for (int f = 0; f < 3; f++) begin
      send_byte(sync, 1'b0, 1'b0, 1'b0);
      send_byte(8'(2 * f + 1), 1'b1, 1'b0, 1'b0);
      send_byte(8'(2 * f + 2), 1'b1, 1'b0, 1'b0);
    end
    chk("t4_drop", {24'h0, drop_cnt}, 2);
    chk("t4_drop_model", {24'h0, drop_cnt}, drop_exp);
    chk("t4_valid", {31'h0, out_valid}, 1);
    chk("t4_head", {24'h0, out_data}, 8'h01);
    rdy_base = 1'b1;
    idle(8);
    chk("t4_sb_left", exp_q.size(), 0);
    chk("t4_valid_end", {31'h0, out_valid}, 0);

    // full FIFO rescued by a pop on the completing cycle
    rdy_base = 1'b0;
    send_byte(sync, 1'b0, 1'b0, 1'b0);
    send_byte(8'h11, 1'b1, 1'b0, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0, 1'b0);
    send_byte(sync, 1'b0, 1'b0, 1'b0);
    send_byte(8'h33, 1'b1, 1'b0, 1'b0);
    send_byte(8'h44, 1'b1, 1'b0, 1'b0);
    send_byte(sync, 1'b0, 1'b0, 1'b0);
    send_byte(8'h55, 1'b1, 1'b0, 1'b1);
    send_byte(8'h66, 1'b1, 1'b0, 1'b1);
    chk("t5_drop", {24'h0, drop_cnt}, 2);
    chk("t5_head", {24'h0, out_data}, 8'h33);
    rdy_base = 1'b1;
    idle(8);
    chk("t5_sb_left", exp_q.size(), 0);

    // sync value inside data, then reset mid-word
    do_reset();
    chk("t6_drop_rst", {24'h0, drop_cnt}, 0);
    rdy_base = 1'b1;
    send_byte(sync, 1'b0, 1'b0, 1'b0);
    send_byte(8'hB1, 1'b1, 1'b0, 1'b0);
    send_byte(8'h77, 1'b1, 1'b0, 1'b0);
    idle(4);
    chk("t6_sb_left", exp_q.size(), 0);
    rdy_base = 1'b0;
    send_byte(sync, 1'b0, 1'b0, 1'b0);
    send_byte(8'hAB, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, rdy_base, 1'b0, 8'h00);
    chk("t6_pending", {31'h0, out_valid}, 1);
    bit_vld = 1'b0;
    reset   = 1'b0;
    #2;
    chk("t6_async_valid", {31'h0, out_valid}, 0);
    chk("t6_async_locked", {31'h0, locked}, 0);
    chk("t6_async_data", {24'h0, out_data}, 0);
    exp_q.delete();
    drop_exp = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    rdy_base = 1'b1;
    send_byte(8'hCD, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("t6_no_sync_valid", {31'h0, out_valid}, 0);
    chk("t6_no_sync_locked", {31'h0, locked}, 0);
    send_byte(sync, 1'b0, 1'b0, 1'b0);
    send_byte(8'h12, 1'b1, 1'b0, 1'b0);
    send_byte(8'h34, 1'b1, 1'b0, 1'b0);
    idle(4);
    chk("t6_resync_left", exp_q.size(), 0);
    chk("t6_drop_end", {24'h0, drop_cnt}, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fsm_out_framer.md
Name: fsm_out_framer

Overview:
- Downstream consumer of the 2-input Mealy FSM's 1-bit output stream `o`.
- Hunts for a sync pattern in the serial bit stream, then deserialises FRAME_WORDS words of WORD_W bits, MSB first.
- Buffers completed words in a small FIFO with a valid/ready output handshake.
- Counts words dropped on overflow. Feeds the word-level checker/logging stage.

Parameters:
- WORD_W, 8, bits per deserialised word (≥2).
- SYNC_W, 8, sync pattern length in bits (≥2).
- SYNC_PAT, 8'hB1, sync pattern, MSB received first; must be nonzero.
- FRAME_WORDS, 2, words collected per sync before re-hunting (≥1).
- FIFO_DEPTH, 4, word FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset: 0 clears all state immediately; release is sampled on clk.
- bit_in  in  1  serial bit from the FSM output `o`.
- bit_vld  in  1  bit_in is sampled this cycle when 1; tie high for per-clock FSM output.
- out_data  out  WORD_W  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head this cycle.
- locked  out  1  1 while in COLLECT state.
- drop_cnt  out  8  words lost to a full FIFO; saturates at 255.

Behaviour:
- Reset values:
  - State HUNT, sync history 0, word shift register 0, bit_cnt 0, word_cnt 0.
  - FIFO empty; out_valid 0, out_data 0, locked 0, drop_cnt 0.
- Reset asserted mid-frame or mid-word discards everything, including FIFO contents. A new sync is required afterwards.
- All state holds when bit_vld=0. The FIFO pop path is independent of bit_vld.
- HUNT:
  - On bit_vld: hist <= {hist[SYNC_W-2:0], bit_in}.
  - If that new value equals SYNC_PAT: next state COLLECT, bit_cnt=0, word_cnt=0.
  - locked goes 1 on the clock edge that samples the last sync bit.
- COLLECT:
  - On bit_vld: word <= {word[WORD_W-2:0], bit_in}; bit_cnt++.
  - When bit_cnt==WORD_W-1 with bit_vld, the word is complete: push {word[WORD_W-2:0], bit_in} and set bit_cnt=0.
  - Sync pattern bits inside data are not detected.
- End of frame: after the FRAME_WORDS-th word completes, go to HUNT, clear hist to 0, and drop locked on the same edge.
- Push rule: the push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
- Overflow: otherwise the word is discarded and drop_cnt increments, saturating at 255. A dropped word still counts toward FRAME_WORDS.
- Pop: occurs when out_valid && out_ready. out_data and out_valid are registered FIFO outputs.
- Latency: a pushed word appears on out_data with out_valid=1 on the edge following the clock that sampled its last bit. The FIFO is write-then-visible, with no bypass.
- Simultaneous push and pop on an empty FIFO cannot happen (out_valid=0, so there is no pop).
- Full/empty pointers: one extra wrap bit; empty when pointers are equal; full when indices are equal and wrap bits differ.
- count stays in range 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package fsm_out_pkg holds:
  - state encoding localparams ST_HUNT=1'b0, ST_COLLECT=1'b1;
  - DROP_W=8;
  - default SYNC_PAT.
- Sub-module fsm_out_fifo: parameterised synchronous FIFO (WIDTH, DEPTH) with push/pop/full/empty/count. It shares clk and reset, using the same async active-low reset.
- The framer top contains the hunt/collect FSM, counters, drop counter and FIFO instance.

Test Plan:
1. Reset low for 3 cycles, then high, no bits → out_valid=0, locked=0, drop_cnt=0, out_data=0.
2. bit_vld=1, out_ready=1, stream 0xB1,0x3C,0x5A (MSB first) → locked=1 after the 8th bit; out_valid pulses with 0x3C, then 0x5A; locked=0 after the 16th data bit; drop_cnt=0.
3. Same stream with bit_vld toggling 1/0 every cycle → identical words in order; sync then held correctly; no extra words.
4. out_ready=0, three frames (0xB1 + 2 words each; words 0x01..0x06) → FIFO holds 0x01..0x04, drop_cnt=2. Then out_ready=1 → 0x01,0x02,0x03,0x04 popped in order, then out_valid=0.
5. FIFO full (4 words) with out_ready=1 on the cycle a 5th word completes → no drop, drop_cnt unchanged, count stays 4.
6. Stream 0xB1,0xB1,0x77:
   - words 0xB1 and 0x77 are output; the second sync is treated as data;
   - reset asserted mid-word of the next frame → all outputs return to reset values immediately, FIFO empties, and the next word requires a fresh 0xB1.
